// File: rtl/miriscv_cmd_decoder.sv
// Streaming RV32I instruction classifier: decode, FIFO buffering and per-command counters.
// Optional M-extension decode and counters are enabled by defining MIRISCV_DEC_MEXT_EN.
module miriscv_cmd_decoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              in_instr_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [5:0]               out_cmd_o,
  output logic [4:0]               out_rd_o,
  output logic                     out_illegal_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o,
  input  logic [5:0]               stat_sel_i,
  input  logic                     stat_clr_i,
  output logic [CNT_W-1:0]         stat_cnt_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned NCMD  = 64;

  localparam logic [5:0] C_NOP     = 6'd0;
  localparam logic [5:0] C_ADD     = 6'd1;
  localparam logic [5:0] C_SUB     = 6'd2;
  localparam logic [5:0] C_XOR     = 6'd3;
  localparam logic [5:0] C_OR      = 6'd4;
  localparam logic [5:0] C_AND     = 6'd5;
  localparam logic [5:0] C_SLL     = 6'd6;
  localparam logic [5:0] C_SRL     = 6'd7;
  localparam logic [5:0] C_SRA     = 6'd8;
  localparam logic [5:0] C_SLT     = 6'd9;
  localparam logic [5:0] C_SLTU    = 6'd10;
  localparam logic [5:0] C_ADDI    = 6'd11;
  localparam logic [5:0] C_XORI    = 6'd12;
  localparam logic [5:0] C_ORI     = 6'd13;
  localparam logic [5:0] C_ANDI    = 6'd14;
  localparam logic [5:0] C_SLLI    = 6'd15;
  localparam logic [5:0] C_SRLI    = 6'd16;
  localparam logic [5:0] C_SRAI    = 6'd17;
  localparam logic [5:0] C_SLTI    = 6'd18;
  localparam logic [5:0] C_SLTUI   = 6'd19;
  localparam logic [5:0] C_LB      = 6'd20;
  localparam logic [5:0] C_LH      = 6'd21;
  localparam logic [5:0] C_LW      = 6'd22;
  localparam logic [5:0] C_LBU     = 6'd23;
  localparam logic [5:0] C_LHU     = 6'd24;
  localparam logic [5:0] C_SB      = 6'd25;
  localparam logic [5:0] C_SH      = 6'd26;
  localparam logic [5:0] C_SW      = 6'd27;
  localparam logic [5:0] C_BEQ     = 6'd28;
  localparam logic [5:0] C_BNE     = 6'd29;
  localparam logic [5:0] C_BLT     = 6'd30;
  localparam logic [5:0] C_BGE     = 6'd31;
  localparam logic [5:0] C_BLTU    = 6'd32;
  localparam logic [5:0] C_BGEU    = 6'd33;
  localparam logic [5:0] C_JAL     = 6'd34;
  localparam logic [5:0] C_JALR    = 6'd35;
  localparam logic [5:0] C_LUI     = 6'd36;
  localparam logic [5:0] C_AUIPC   = 6'd37;
  localparam logic [5:0] C_SYSTEM  = 6'd38;
  localparam logic [5:0] C_MISCMEM = 6'd39;
  localparam logic [5:0] C_ILLEGAL = 6'd63;

`ifdef MIRISCV_DEC_MEXT_EN
  localparam logic [5:0]      C_MUL    = 6'd40;
  localparam logic [NCMD-1:0] CNT_MASK = 64'h8000_FFFF_FFFF_FFFF;
`else
  localparam logic [NCMD-1:0] CNT_MASK = 64'h8000_00FF_FFFF_FFFF;
`endif

  typedef struct packed {
    logic [5:0] cmd;
    logic [4:0] rd;
  } entry_t;

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [5:0]  w_cmd;
  logic        w_rd_en;
  entry_t      w_entry;

  assign w_opcode = in_instr_i[6:0];
  assign w_f3     = in_instr_i[14:12];
  assign w_f7     = in_instr_i[31:25];

  // Combinational classification of the incoming word
  always_comb begin
    w_cmd   = C_ILLEGAL;
    w_rd_en = 1'b1;
    case (w_opcode)
      7'b0110011: begin
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'b000:  w_cmd = C_ADD;
            3'b001:  w_cmd = C_SLL;
            3'b010:  w_cmd = C_SLT;
            3'b011:  w_cmd = C_SLTU;
            3'b100:  w_cmd = C_XOR;
            3'b101:  w_cmd = C_SRL;
            3'b110:  w_cmd = C_OR;
            default: w_cmd = C_AND;
          endcase
        end else if (w_f7 == 7'b0100000) begin
          if (w_f3 == 3'b000)      w_cmd = C_SUB;
          else if (w_f3 == 3'b101) w_cmd = C_SRA;
        end
`ifdef MIRISCV_DEC_MEXT_EN
        else if (w_f7 == 7'b0000001) begin
          w_cmd = C_MUL + 6'(w_f3);
        end
`endif
      end
      7'b0010011: begin
        case (w_f3)
          3'b000:  w_cmd = (in_instr_i == 32'h0000_0013) ? C_NOP : C_ADDI;
          3'b010:  w_cmd = C_SLTI;
          3'b011:  w_cmd = C_SLTUI;
          3'b100:  w_cmd = C_XORI;
          3'b110:  w_cmd = C_ORI;
          3'b111:  w_cmd = C_ANDI;
          3'b001:  w_cmd = (w_f7 == 7'b0000000) ? C_SLLI : C_ILLEGAL;
          default: begin
            if (w_f7 == 7'b0000000)      w_cmd = C_SRLI;
            else if (w_f7 == 7'b0100000) w_cmd = C_SRAI;
          end
        endcase
      end
      7'b0000011: begin
        case (w_f3)
          3'b000:  w_cmd = C_LB;
          3'b001:  w_cmd = C_LH;
          3'b010:  w_cmd = C_LW;
          3'b100:  w_cmd = C_LBU;
          3'b101:  w_cmd = C_LHU;
          default: w_cmd = C_ILLEGAL;
        endcase
      end
      7'b0100011: begin
        w_rd_en = 1'b0;
        case (w_f3)
          3'b000:  w_cmd = C_SB;
          3'b001:  w_cmd = C_SH;
          3'b010:  w_cmd = C_SW;
          default: w_cmd = C_ILLEGAL;
        endcase
      end
      7'b1100011: begin
        w_rd_en = 1'b0;
        case (w_f3)
          3'b000:  w_cmd = C_BEQ;
          3'b001:  w_cmd = C_BNE;
          3'b100:  w_cmd = C_BLT;
          3'b101:  w_cmd = C_BGE;
          3'b110:  w_cmd = C_BLTU;
          3'b111:  w_cmd = C_BGEU;
          default: w_cmd = C_ILLEGAL;
        endcase
      end
      7'b1101111: w_cmd = C_JAL;
      7'b1100111: w_cmd = (w_f3 == 3'b000) ? C_JALR : C_ILLEGAL;
      7'b0110111: w_cmd = C_LUI;
      7'b0010111: w_cmd = C_AUIPC;
      7'b1110011: begin
        w_cmd   = C_SYSTEM;
        w_rd_en = 1'b0;
      end
      7'b0001111: begin
        w_cmd   = C_MISCMEM;
        w_rd_en = 1'b0;
      end
      default: w_cmd = C_ILLEGAL;
    endcase
    if (w_cmd == C_ILLEGAL) w_rd_en = 1'b0;
  end

  assign w_entry.cmd = w_cmd;
  assign w_entry.rd  = w_rd_en ? in_instr_i[11:7] : 5'd0;

  entry_t              r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [LW-1:0]       r_level;
  logic                r_in_ready;
  logic                r_out_valid;
  entry_t              r_head;
  logic [CNT_W-1:0]    r_cnt [NCMD];
  logic [CNT_W-1:0]    r_stat;

  logic                w_push;
  logic                w_pop;
  logic [AW-1:0]       w_rd_ptr_nxt;
  logic [LW-1:0]       w_level_nxt;

  assign w_push       = in_valid_i && r_in_ready;
  assign w_pop        = r_out_valid && out_ready_i;
  assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
  assign w_level_nxt  = r_level + LW'(w_push) - LW'(w_pop);

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  // Pointers, level and a registered copy of the next head (held when empty)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_head      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_level     <= w_level_nxt;
      r_in_ready  <= (w_level_nxt != LW'(DEPTH));
      r_out_valid <= (w_level_nxt != '0);
      if (w_level_nxt != '0) begin
        if ((r_level == '0) || ((r_level == LW'(1)) && w_pop)) r_head <= w_entry;
        else                                                   r_head <= r_mem[w_rd_ptr_nxt];
      end
    end
  end

  // Saturating occurrence counters; clear takes priority over a same-cycle increment
  always_ff @(posedge clk_i) begin
    if (rst_i || stat_clr_i) begin
      for (int i = 0; i < int'(NCMD); i++) r_cnt[i] <= '0;
    end else if (w_push && CNT_MASK[w_cmd] && (r_cnt[w_cmd] != '1)) begin
      r_cnt[w_cmd] <= r_cnt[w_cmd] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_stat <= '0;
    else       r_stat <= CNT_MASK[stat_sel_i] ? r_cnt[stat_sel_i] : '0;
  end

  assign in_ready_o    = r_in_ready;
  assign out_valid_o   = r_out_valid;
  assign out_cmd_o     = r_head.cmd;
  assign out_rd_o      = r_head.rd;
  assign out_illegal_o = (r_head.cmd == C_ILLEGAL);
  assign fifo_level_o  = r_level;
  assign stat_cnt_o    = r_stat;

endmodule

// File: tb/tb_miriscv_cmd_decoder.sv
// Directed bench for miriscv_cmd_decoder: scoreboarded decode stream, FIFO full/empty, counters.
module tb_miriscv_cmd_decoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_instr = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [5:0]        out_cmd;
  logic [4:0]        out_rd;
  logic              out_illegal;
  logic [LW-1:0]     fifo_level;
  logic [5:0]        stat_sel = '0;
  logic              stat_clr = 1'b0;
  logic [CNT_W-1:0]  stat_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [10:0] exp_q [$];

  miriscv_cmd_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(in_instr),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_cmd_o(out_cmd), .out_rd_o(out_rd), .out_illegal_o(out_illegal),
    .fifo_level_o(fifo_level),
    .stat_sel_i(stat_sel), .stat_clr_i(stat_clr), .stat_cnt_o(stat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one word; its expected result is queued once the DUT signals acceptance
  task automatic push(input logic [31:0] ins, input logic [5:0] c, input logic [4:0] r);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_instr = ins;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("push_accept_timeout", 64'(in_ready), 64'd1);
    if (in_ready) exp_q.push_back({c, r});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard     = 0;
    out_ready = 1'b1;
    while (out_valid && guard < 100) begin
      tick();
      guard++;
    end
    check("drain_empty", 64'(out_valid), 64'd0);
    check("drain_sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic read_cnt(input logic [5:0] sel, input string tag, input logic [63:0] exp);
    stat_sel = sel;
    tick();
    tick();
    check(tag, 64'(stat_cnt), exp);
  endtask

  // Scoreboard: compare the head each time a pop is about to happen
  always @(negedge clk) begin
    logic [10:0] e;
    if (!rst && out_valid && out_ready) begin
      check("sb_has_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_cmd", 64'(out_cmd), 64'(e[10:5]));
        check("sb_rd", 64'(out_rd), 64'(e[4:0]));
        check("sb_illegal", 64'(out_illegal), 64'(e[10:5] == 6'd63));
      end
    end
  end

  initial begin
    int n_ill;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_cmd", 64'(out_cmd), 64'd0);
    check("rst_out_rd", 64'(out_rd), 64'd0);
    check("rst_out_illegal", 64'(out_illegal), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_stat", 64'(stat_cnt), 64'd0);

    out_ready = 1'b1;
    push(32'h0020_81B3, 6'd1, 5'd3);
    check("add_head_valid", 64'(out_valid), 64'd1);
    check("add_head_cmd", 64'(out_cmd), 64'd1);
    stat_sel = 6'd1;
    tick();
    check("add_counter", 64'(stat_cnt), 64'd1);

    push(32'h0000_0013, 6'd0, 5'd0);
    push(32'h0010_0093, 6'd11, 5'd1);
    check("stream_level", 64'(fifo_level), 64'd1);
    push(32'h4020_D093, 6'd17, 5'd1);
    push(32'hFFFF_FFFF, 6'd63, 5'd0);
    push(32'h0000_2003, 6'd22, 5'd0);
    push(32'h0000_3003, 6'd63, 5'd0);
    push(32'h4000_0033, 6'd2, 5'd0);
    push(32'h0011_2023, 6'd27, 5'd0);
    push(32'h0000_0063, 6'd28, 5'd0);
    push(32'h0080_00EF, 6'd34, 5'd1);
    push(32'h1234_5537, 6'd36, 5'd10);
    push(32'h0000_0073, 6'd38, 5'd0);
    push(32'h0FF0_000F, 6'd39, 5'd0);
    push(32'h0200_9093, 6'd63, 5'd0);
    push(32'h0000_1067, 6'd63, 5'd0);
`ifdef MIRISCV_DEC_MEXT_EN
    push(32'h0273_02B3, 6'd40, 5'd5);
    n_ill = 4;
`else
    push(32'h0273_02B3, 6'd63, 5'd0);
    n_ill = 5;
`endif
    drain();

    // Fill to full with the consumer stalled, then release
    out_ready = 1'b0;
    for (int i = 1; i <= int'(DEPTH); i++)
      push(32'h0010_0013 | (32'(i) << 7), 6'd11, 5'(i));
    check("full_ready_low", 64'(in_ready), 64'd0);
    check("full_level", 64'(fifo_level), 64'(DEPTH));
    in_valid = 1'b1;
    in_instr = 32'h0010_0013 | (32'(DEPTH + 1) << 7);
    tick();
    tick();
    check("full_hold_ready", 64'(in_ready), 64'd0);
    check("full_hold_level", 64'(fifo_level), 64'(DEPTH));
    out_ready = 1'b1;
    tick();
    check("ready_after_pop", 64'(in_ready), 64'd1);
    check("level_after_pop", 64'(fifo_level), 64'(DEPTH - 1));
    push(32'h0010_0013 | (32'(DEPTH + 1) << 7), 6'd11, 5'(DEPTH + 1));
    push(32'h0010_0013 | (32'(DEPTH + 2) << 7), 6'd11, 5'(DEPTH + 2));
    drain();
    tick();
    check("empty_hold_cmd", 64'(out_cmd), 64'd11);
    check("empty_hold_rd", 64'(out_rd), 64'(DEPTH + 2));
    check("empty_level", 64'(fifo_level), 64'd0);

    read_cnt(6'd0, "cnt_nop", 64'd1);
    read_cnt(6'd11, "cnt_addi", 64'(DEPTH + 3));
    read_cnt(6'd63, "cnt_illegal", 64'(n_ill));
    read_cnt(6'd50, "cnt_reserved", 64'd0);

    // Reset with entries buffered
    out_ready = 1'b0;
    push(32'h0020_81B3, 6'd1, 5'd3);
    push(32'h0020_81B3, 6'd1, 5'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("midrst_level", 64'(fifo_level), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd1);
    check("midrst_cmd", 64'(out_cmd), 64'd0);
    read_cnt(6'd1, "midrst_cnt", 64'd0);

    // Saturation and clear priority
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) push(32'h0020_81B3, 6'd1, 5'd3);
    read_cnt(6'd1, "cnt_saturate", 64'd255);
    stat_clr = 1'b1;
    push(32'h0020_81B3, 6'd1, 5'd3);
    stat_clr = 1'b0;
    check("stat_pre_clear", 64'(stat_cnt), 64'd255);
    tick();
    check("cnt_clear_wins", 64'(stat_cnt), 64'd0);
    push(32'h0020_81B3, 6'd1, 5'd3);
    read_cnt(6'd1, "cnt_after_clear", 64'd1);
    read_cnt(6'd40, "cnt_mul", 64'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
